dp_instr_encoder: RTL and testbench

- Packs decoded data-processing fields (cond, OP, S, rn/rd/rm/rs, shift type, immediates, format DP0/DP1/DP2) into 32-bit ARM instruction words.
- Applies the core decoder's legality rules, so every word it emits decodes with Und_Ins=0.
- Legal words are queued in a small FIFO, each tagged with a sequential instruction-memory word address.
- Sits between the test/program-generation front end and the instruction-memory write port. It is the inverse of the core's instruction decode stage.

---
 rtl/dp_isa_pkg.sv | 51 +++++
 rtl/dp_enc_fifo.sv | 50 +++++
 rtl/dp_instr_encoder.sv | 117 +++++++++++
 tb/tb_dp_instr_encoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_isa_pkg.sv
// Shared data-processing ISA definitions: opcodes, format codes, and the
// legality rule set used by both the core decoder and the encoder.
package dp_isa_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [1:0] FMT_DP0 = 2'd0;
    localparam logic [1:0] FMT_DP1 = 2'd1;
    localparam logic [1:0] FMT_DP2 = 2'd2;
    localparam logic [1:0] FMT_RSV = 2'd3;

    localparam logic [2:0] CLASS_DP_REG = 3'b000;
    localparam logic [2:0] CLASS_DP_IMM = 3'b001;

    localparam logic [3:0] PC = 4'hF;
    localparam logic [3:0] LR = 4'hE;

    // A bundle is legal when it decodes with Und_Ins=0.
    function automatic logic dp_legal(
        input logic [1:0] fmt,
        input logic [3:0] op,
        input logic       s,
        input logic [3:0] rn,
        input logic [3:0] rd
    );
        logic exc_ret;
        logic ok;
        exc_ret = s && (rn == LR) && ((op == OP_MOV) || (op == OP_SUB));
        ok = 1'b1;
        if (fmt == FMT_RSV)              ok = 1'b0;
        if ((op[3:2] == 2'b10) && !s)    ok = 1'b0;
        if ((rd == PC) && !exc_ret)      ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/dp_enc_fifo.sv
// Small synchronous FIFO with occupancy count; head entry is always visible.
module dp_enc_fifo #(
    parameter int unsigned W     = 40,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push   = push && (count != CW'(DEPTH));
    assign do_pop    = pop && (count != '0);
    assign valid     = (count != '0);
    assign head_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dp_instr_encoder.sv
// Packs decoded data-processing fields into ARM instruction words, drops
// illegal bundles, and queues legal words with sequential IMEM addresses.
module dp_instr_encoder
    import dp_isa_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned REJ_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cond,
    input  logic [1:0]        in_fmt,
    input  logic [3:0]        in_op,
    input  logic              in_s,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rs,
    input  logic [4:0]        in_imm5,
    input  logic [1:0]        in_shift_type,
    input  logic [3:0]        in_rm,
    input  logic [11:0]       in_imm12,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              rej_pulse,
    output logic [REJ_W-1:0]  rej_count,
    output logic [ADDR_W-1:0] word_count
);
    localparam int unsigned ENTRY_W = 32 + ADDR_W;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-1:0]  addr;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] head;
    logic [31:0]        word;
    logic               accept;
    logic               legal;
    logic               push;

    assign in_ready = !rst && !base_load && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign accept   = in_valid && in_ready;
    assign legal    = dp_legal(in_fmt, in_op, in_s, in_rn, in_rd);
    assign push     = accept && legal;

    // Field packing; reserved format leaves the class bits zero but is never pushed.
    always_comb begin
        word        = '0;
        word[31:28] = in_cond;
        word[24:21] = in_op;
        word[20]    = in_s;
        word[19:16] = in_rn;
        word[15:12] = in_rd;
        case (in_fmt)
            FMT_DP0: begin
                word[27:25] = CLASS_DP_REG;
                word[11:7]  = in_imm5;
                word[6:5]   = in_shift_type;
                word[4]     = 1'b0;
                word[3:0]   = in_rm;
            end
            FMT_DP1: begin
                word[27:25] = CLASS_DP_REG;
                word[11:8]  = in_rs;
                word[7]     = 1'b0;
                word[6:5]   = in_shift_type;
                word[4]     = 1'b1;
                word[3:0]   = in_rm;
            end
            FMT_DP2: begin
                word[27:25] = CLASS_DP_IMM;
                word[11:0]  = in_imm12;
            end
            default: ;
        endcase
    end

    // Address counter, statistics and reject strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            word_count <= '0;
            rej_count  <= '0;
            rej_pulse  <= 1'b0;
        end else begin
            rej_pulse <= accept && !legal;
            if (base_load)  addr <= base_addr;
            else if (push)  addr <= addr + ADDR_W'(1);
            if (push) word_count <= word_count + ADDR_W'(1);
            if (accept && !legal && (rej_count != '1))
                rej_count <= rej_count + REJ_W'(1);
        end
    end

    dp_enc_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({word, addr}),
        .pop       (out_ready),
        .head_data (head),
        .valid     (out_valid),
        .count     (fifo_count)
    );

    assign out_word = head[ENTRY_W-1:ADDR_W];
    assign out_addr = head[ADDR_W-1:0];

endmodule

// File: tb/tb_dp_instr_encoder.sv
// Directed bench for dp_instr_encoder with hand-computed instruction words.
module tb_dp_instr_encoder;
    import dp_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        base_load;
    logic [7:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cond;
    logic [1:0]  in_fmt;
    logic [3:0]  in_op;
    logic        in_s;
    logic [3:0]  in_rn;
    logic [3:0]  in_rd;
    logic [3:0]  in_rs;
    logic [4:0]  in_imm5;
    logic [1:0]  in_shift_type;
    logic [3:0]  in_rm;
    logic [11:0] in_imm12;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [7:0]  out_addr;
    logic        rej_pulse;
    logic [7:0]  rej_count;
    logic [7:0]  word_count;

    int vectors    = 0;
    int miscompares = 0;

    dp_instr_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .base_load     (base_load),
        .base_addr     (base_addr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_cond       (in_cond),
        .in_fmt        (in_fmt),
        .in_op         (in_op),
        .in_s          (in_s),
        .in_rn         (in_rn),
        .in_rd         (in_rd),
        .in_rs         (in_rs),
        .in_imm5       (in_imm5),
        .in_shift_type (in_shift_type),
        .in_rm         (in_rm),
        .in_imm12      (in_imm12),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_word      (out_word),
        .out_addr      (out_addr),
        .rej_pulse     (rej_pulse),
        .rej_count     (rej_count),
        .word_count    (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_f(input logic [1:0] fmt, input logic [3:0] op, input logic s,
                         input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rs,
                         input logic [4:0] imm5, input logic [1:0] typ, input logic [3:0] rm,
                         input logic [11:0] imm12);
        in_fmt = fmt; in_op = op; in_s = s; in_rn = rn; in_rd = rd; in_rs = rs;
        in_imm5 = imm5; in_shift_type = typ; in_rm = rm; in_imm12 = imm12;
    endtask

    // Present the bundle for exactly one rising edge, return at the following negedge.
    task automatic step();
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; base_load = 1'b0; base_addr = '0; in_valid = 1'b0; out_ready = 1'b1;
        in_cond = 4'hE;
        set_f(FMT_DP0, OP_AND, 1'b0, 4'h0, 4'h0, 4'h0, 5'd0, 2'd0, 4'h0, 12'h000);

        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", out_word, 32'h0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_rej_count", 32'(rej_count), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_rej_pulse", 32'(rej_pulse), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // ADD r1,r2,r3
        set_f(FMT_DP0, OP_ADD, 1'b0, 4'd2, 4'd1, 4'd0, 5'd0, 2'd0, 4'd3, 12'h000);
        step();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_word", out_word, 32'hE0821003);
        chk("add_addr", 32'(out_addr), 32'd0);
        // MOV r0,#0xFF
        set_f(FMT_DP2, OP_MOV, 1'b0, 4'd0, 4'd0, 4'd0, 5'd0, 2'd0, 4'd0, 12'h0FF);
        step();
        chk("movi_word", out_word, 32'hE3A000FF);
        chk("movi_addr", 32'(out_addr), 32'd1);
        // CMP r1,r2
        set_f(FMT_DP0, OP_CMP, 1'b1, 4'd1, 4'd0, 4'd0, 5'd0, 2'd0, 4'd2, 12'h000);
        step();
        chk("cmp_word", out_word, 32'hE1510002);
        chk("cmp_addr", 32'(out_addr), 32'd2);
        // ADD r0,r1,r2 LSL r3
        set_f(FMT_DP1, OP_ADD, 1'b0, 4'd1, 4'd0, 4'd3, 5'd0, 2'd0, 4'd2, 12'h000);
        step();
        chk("dp1_word", out_word, 32'hE0810312);
        chk("dp1_addr", 32'(out_addr), 32'd3);
        // MOVS pc,lr
        set_f(FMT_DP0, OP_MOV, 1'b1, 4'hE, 4'hF, 4'd0, 5'd0, 2'd0, 4'hE, 12'h000);
        step();
        chk("movs_word", out_word, 32'hE1BEF00E);
        chk("movs_addr", 32'(out_addr), 32'd4);
        chk("movs_wcount", 32'(word_count), 32'd5);

        // Rejects: rd=pc, reserved format, compare without S
        set_f(FMT_DP0, OP_ADD, 1'b0, 4'd1, 4'hF, 4'd0, 5'd0, 2'd0, 4'd3, 12'h000);
        step();
        chk("rej1_pulse", 32'(rej_pulse), 32'd1);
        chk("rej1_count", 32'(rej_count), 32'd1);
        chk("rej1_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("rej1_pulse_clear", 32'(rej_pulse), 32'd0);
        set_f(FMT_RSV, OP_ADD, 1'b0, 4'd2, 4'd1, 4'd0, 5'd0, 2'd0, 4'd3, 12'h000);
        step();
        chk("rej2_count", 32'(rej_count), 32'd2);
        set_f(FMT_DP0, OP_CMP, 1'b0, 4'd1, 4'd0, 4'd0, 5'd0, 2'd0, 4'd2, 12'h000);
        step();
        chk("rej3_count", 32'(rej_count), 32'd3);
        chk("rej3_wcount", 32'(word_count), 32'd5);
        set_f(FMT_DP0, OP_ADD, 1'b0, 4'd2, 4'd1, 4'd0, 5'd0, 2'd0, 4'd3, 12'h000);
        step();
        chk("post_rej_word", out_word, 32'hE0821003);
        chk("post_rej_addr", 32'(out_addr), 32'd5);
        @(negedge clk);
        chk("drained", 32'(out_valid), 32'd0);

        // Backpressure: fill FIFO, third bundle waits for a pop
        out_ready = 1'b0;
        set_f(FMT_DP2, OP_MOV, 1'b0, 4'd0, 4'd0, 4'd0, 5'd0, 2'd0, 4'd0, 12'h001);
        step();
        chk("fill1_in_ready", 32'(in_ready), 32'd1);
        set_f(FMT_DP2, OP_MOV, 1'b0, 4'd0, 4'd1, 4'd0, 5'd0, 2'd0, 4'd0, 12'h002);
        step();
        chk("full_in_ready", 32'(in_ready), 32'd0);
        set_f(FMT_DP2, OP_MOV, 1'b0, 4'd0, 4'd2, 4'd0, 5'd0, 2'd0, 4'd0, 12'h003);
        in_valid = 1'b1;
        @(negedge clk);
        chk("full_hold_ready", 32'(in_ready), 32'd0);
        chk("full_hold_word", out_word, 32'hE3A00001);
        chk("full_hold_addr", 32'(out_addr), 32'd6);
        out_ready = 1'b1;
        @(negedge clk);
        chk("pop1_word", out_word, 32'hE3A01002);
        chk("pop1_addr", 32'(out_addr), 32'd7);
        chk("pop1_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("third_word", out_word, 32'hE3A02003);
        chk("third_addr", 32'(out_addr), 32'd8);
        chk("third_wcount", 32'(word_count), 32'd9);
        @(negedge clk);
        chk("drained2", 32'(out_valid), 32'd0);

        // base_load blocks accepts for its cycle, then addresses wrap 0xFE..0x00
        base_load = 1'b1; base_addr = 8'hFE;
        set_f(FMT_DP2, OP_MOV, 1'b0, 4'd0, 4'd3, 4'd0, 5'd0, 2'd0, 4'd0, 12'h004);
        in_valid = 1'b1;
        #1;
        chk("bl_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        base_load = 1'b0;
        chk("bl_no_push", 32'(out_valid), 32'd0);
        chk("bl_wcount", 32'(word_count), 32'd9);
        step();
        chk("bl0_word", out_word, 32'hE3A03004);
        chk("bl0_addr", 32'(out_addr), 32'hFE);
        set_f(FMT_DP2, OP_MOV, 1'b0, 4'd0, 4'd4, 4'd0, 5'd0, 2'd0, 4'd0, 12'h005);
        step();
        chk("bl1_word", out_word, 32'hE3A04005);
        chk("bl1_addr", 32'(out_addr), 32'hFF);
        set_f(FMT_DP2, OP_MOV, 1'b0, 4'd0, 4'd5, 4'd0, 5'd0, 2'd0, 4'd0, 12'h006);
        step();
        chk("bl2_word", out_word, 32'hE3A05006);
        chk("bl2_addr", 32'(out_addr), 32'h00);
        chk("bl_wcount2", 32'(word_count), 32'd12);
        @(negedge clk);

        // 197 more rejects bring the count to 200, then queue two words
        set_f(FMT_DP0, OP_ADD, 1'b0, 4'd1, 4'hF, 4'd0, 5'd0, 2'd0, 4'd3, 12'h000);
        in_valid = 1'b1;
        repeat (197) @(negedge clk);
        in_valid = 1'b0;
        chk("rej200_count", 32'(rej_count), 32'd200);
        out_ready = 1'b0;
        set_f(FMT_DP2, OP_MOV, 1'b0, 4'd0, 4'd0, 4'd0, 5'd0, 2'd0, 4'd0, 12'h001);
        step();
        step();
        chk("prerst_valid", 32'(out_valid), 32'd1);
        chk("prerst_in_ready", 32'(in_ready), 32'd0);

        // Reset together with base_load: reset wins
        rst = 1'b1; base_load = 1'b1; base_addr = 8'h55;
        @(negedge clk);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_rej_count", 32'(rej_count), 32'd0);
        chk("mrst_wcount", 32'(word_count), 32'd0);
        chk("mrst_out_word", out_word, 32'h0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0; base_load = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("mrst_idle_ready", 32'(in_ready), 32'd1);
        chk("mrst_idle_valid", 32'(out_valid), 32'd0);

        // Saturation after 300 rejects
        set_f(FMT_DP0, OP_ADD, 1'b0, 4'd1, 4'hF, 4'd0, 5'd0, 2'd0, 4'd3, 12'h000);
        in_valid = 1'b1;
        repeat (300) @(negedge clk);
        in_valid = 1'b0;
        chk("sat_count", 32'(rej_count), 32'd255);
        chk("sat_wcount", 32'(word_count), 32'd0);
        set_f(FMT_DP0, OP_ADD, 1'b0, 4'd2, 4'd1, 4'd0, 5'd0, 2'd0, 4'd3, 12'h000);
        step();
        chk("after_rst_word", out_word, 32'hE0821003);
        chk("after_rst_addr", 32'(out_addr), 32'd0);
        chk("after_rst_wcount", 32'(word_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
